wb_dpbram_be: RTL and testbench
===============================

Name: wb_dpbram_be

Overview:
- Parametrised successor to the team's SDR dual-port block RAM: single clock, two independent ports.
- Adds per-byte write enables, configurable same-port read-during-write mode, and an optional output pipeline register.
- Adds read-valid strobes, deterministic write-write collision resolution and a saturating collision counter.
- Sits between two bus masters (e.g. CPU and DMA) as shared scratchpad memory.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per byte lane; NBYTES = DATA_WIDTH/BYTE_WIDTH.
- ADDR_WIDTH, 10, address width; MEM_DEPTH = 2**ADDR_WIDTH.
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (merged new data).
- OUT_REG, 0, 1 adds one output register stage per port.
- PRIORITY_B, 0, write-write collision winner: 0 = port A, 1 = port B.

Ports:
- i_clk  in  1  clock for both ports.
- i_reset  in  1  asynchronous reset, active high.
- o_ready  out  1  ports accept requests when high.
- i_enA  in  1  port A request.
- i_weA  in  NBYTES  port A byte write enables; all zero = read.
- i_addrA  in  ADDR_WIDTH  port A address.
- i_dinA  in  DATA_WIDTH  port A write data.
- o_doutA  out  DATA_WIDTH  port A read data.
- o_validA  out  1  o_doutA valid strobe.
- i_enB, i_weB, i_addrB, i_dinB, o_doutB, o_validB: same widths and meanings as port A, for port B.
- o_collision  out  1  one-cycle pulse on a write-write collision.
- o_coll_count  out  16  saturating count of write-write collisions.

Behaviour:
- Reset (async assert, sync release):
  - o_doutA/B = 0, o_validA/B = 0, o_collision = 0, o_coll_count = 0, o_ready = 0, pipeline regs cleared.
  - Memory contents are not reset.
- Accepted request: a port's request is accepted when i_enX && o_ready at a clock edge.
  - Every accepted request (read or write) produces a read of the addressed word.
- Latency:
  - Data and o_validX appear 1 clock after acceptance (OUT_REG=0) or 2 clocks after (OUT_REG=1).
  - o_validX is a one-cycle pulse per accepted request.
  - Back-to-back requests give one result per cycle.
- Hold: o_doutX holds its last value when no result is due.
- Byte writes: lane k is written iff i_weX[k]; lanes with i_weX[k]=0 are untouched.
- Same-port read-during-write:
  - RDW_MODE=0: returns the pre-write word.
  - RDW_MODE=1: returns the pre-write word with this port's enabled lanes replaced by i_dinX.
- Cross-port write while the other port only reads the same address: the reader always gets the pre-write word, in both RDW modes.
- Write-write collision (both accepted, same address, both i_we nonzero):
  - The winner (PRIORITY_B) writes all its enabled lanes.
  - The loser writes only the lanes the winner does not enable.
  - Lanes enabled by neither port are untouched.
  - o_collision pulses the following cycle.
  - o_coll_count increments by 1 and saturates at 16'hFFFF.
- Each port's returned data reflects only that port's own RDW merge, never the other port's write.
- Requests while o_ready=0 are ignored: no write, no o_valid.
- Reset mid-operation: in-flight results are discarded, with no o_valid after reset release.

Optional Feature:
- Macro: WB_DPBRAM_CLEAR_EN.
- Defined: a clear FSM runs after reset release.
  - States: IDLE -> CLEAR -> READY.
  - IDLE lasts 1 cycle.
  - CLEAR writes zero to address 0..MEM_DEPTH-1, one word per cycle, using a counter that terminates at MEM_DEPTH-1.
  - READY asserts o_ready and is terminal until the next reset.
  - o_ready = 0 through IDLE and CLEAR, so it rises MEM_DEPTH+1 cycles after release.
  - Reset during CLEAR restarts the sweep.
- Not defined: no FSM; o_ready rises on the first clock edge after reset release and memory is uninitialised.

Test Plan:
- Reset, then A writes 32'hDEADBEEF at 0x010 with we=4'hF; B reads 0x010 next cycle -> o_validB after 1 cycle (OUT_REG=0), o_doutB=32'hDEADBEEF.
- Word at 0x020 = 32'h11223344; A writes 32'hAABBCCDD with we=4'b0101 -> later read returns 32'h11BB33DD.
- RDW_MODE=0 vs 1: 0x030 holds 32'h0; A writes 32'h5A5A5A5A with we=4'hF -> same-cycle o_doutA = 32'h0 (mode 0) or 32'h5A5A5A5A (mode 1); B reading 0x030 the same cycle gets 32'h0 in both modes.
- PRIORITY_B=0: A writes 32'hAAAAAAAA with we=4'b0011 and B writes 32'hBBBBBBBB with we=4'b1110 to 0x040 -> word = 32'hBBBBAAAA, o_collision pulse, o_coll_count=1; force 70000 collisions -> count stays 16'hFFFF.
- OUT_REG=1: reads of 0x010, 0x011, 0x012 on three consecutive cycles -> o_validA high for three consecutive cycles starting 2 cycles after the first request, data in order.
- WB_DPBRAM_CLEAR_EN, ADDR_WIDTH=4: release reset -> o_ready rises after 17 cycles, all 16 words read 0, requests issued before o_ready give no o_valid; reset asserted during CLEAR -> sweep restarts.

Source files
------------

// File: rtl/wb_dpbram_be_if.sv
// ---------------------------------------------------------------------------
// wb_dpbram_be_if
// Bus bundle for the byte-enable dual-port scratchpad RAM (wb_dpbram_be).
//
// Signals (names match the RAM's port list):
//   o_ready                        RAM accepts requests when high
//   i_enA/B                        port request
//   i_weA/B      [NBYTES-1:0]      byte write enables, all zero = read
//   i_addrA/B    [ADDR_WIDTH-1:0]  word address
//   i_dinA/B     [DATA_WIDTH-1:0]  write data
//   o_doutA/B    [DATA_WIDTH-1:0]  read data (held between results)
//   o_validA/B                     one-cycle strobe per returned result
//   o_collision                    pulse after a write-write collision
//   o_coll_count [15:0]            saturating collision count
//
// Modports: master = bus masters / testbench, slave = the RAM.
// ---------------------------------------------------------------------------
interface wb_dpbram_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;

  logic                  o_ready;
  logic                  i_enA;
  logic [NBYTES-1:0]     i_weA;
  logic [ADDR_WIDTH-1:0] i_addrA;
  logic [DATA_WIDTH-1:0] i_dinA;
  logic [DATA_WIDTH-1:0] o_doutA;
  logic                  o_validA;
  logic                  i_enB;
  logic [NBYTES-1:0]     i_weB;
  logic [ADDR_WIDTH-1:0] i_addrB;
  logic [DATA_WIDTH-1:0] i_dinB;
  logic [DATA_WIDTH-1:0] o_doutB;
  logic                  o_validB;
  logic                  o_collision;
  logic [15:0]           o_coll_count;

  modport master (
    input  o_ready, o_doutA, o_validA, o_doutB, o_validB, o_collision, o_coll_count,
    output i_enA, i_weA, i_addrA, i_dinA, i_enB, i_weB, i_addrB, i_dinB
  );

  modport slave (
    output o_ready, o_doutA, o_validA, o_doutB, o_validB, o_collision, o_coll_count,
    input  i_enA, i_weA, i_addrA, i_dinA, i_enB, i_weB, i_addrB, i_dinB
  );
endinterface

// File: rtl/wb_dpbram_be.sv
// ---------------------------------------------------------------------------
// wb_dpbram_be
// Single-clock true dual-port RAM with per-byte write enables, shared as a
// scratchpad between two bus masters.
//
// Ports:
//   i_clk    clock for both ports
//   i_reset  asynchronous active-high reset (memory contents are kept)
//   bus      wb_dpbram_be_if.slave: request/response signals of ports A and
//            B, o_ready, collision pulse and saturating collision counter
//
// Parameters: DATA_WIDTH, BYTE_WIDTH, ADDR_WIDTH, RDW_MODE (0 read-first,
// 1 write-first on the same port), OUT_REG (extra output stage),
// PRIORITY_B (0: port A wins write-write collisions, 1: port B wins).
//
// Build option: define WB_DPBRAM_CLEAR_EN to zero the whole array after
// every reset release (o_ready stays low for MEM_DEPTH+1 cycles). Without
// it, o_ready rises on the first clock edge after release.
// ---------------------------------------------------------------------------
module wb_dpbram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0,
  parameter int PRIORITY_B = 0
) (
  input logic           i_clk,
  input logic           i_reset,
  wb_dpbram_be_if.slave bus
);
  localparam int NBYTES    = DATA_WIDTH / BYTE_WIDTH;
  localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;

  logic                  ready;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef WB_DPBRAM_CLEAR_EN
  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_READY} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    ready     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_READY;
        else clr_cnt_d = clr_cnt_q + 1'b1;
      end
      ST_READY: ready = 1'b1;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign clr_addr = clr_cnt_q;
`else
  logic ready_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) ready_q <= 1'b0;
    else         ready_q <= 1'b1;
  end

  assign ready    = ready_q;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  assign bus.o_ready = ready;

  // Request acceptance and write-write collision detection
  logic acc_a, acc_b, coll;
  assign acc_a = bus.i_enA & ready;
  assign acc_b = bus.i_enB & ready;
  assign coll  = acc_a & acc_b & (bus.i_addrA == bus.i_addrB) & (|bus.i_weA) & (|bus.i_weB);

  // The loser of a collision keeps only lanes the winner leaves alone, so
  // the two ports never write the same lane of the same word.
  logic [NBYTES-1:0] wr_a, wr_b;
  always_comb begin
    wr_a = acc_a ? bus.i_weA : '0;
    wr_b = acc_b ? bus.i_weB : '0;
    if (coll) begin
      if (PRIORITY_B != 0) wr_a = wr_a & ~bus.i_weB;
      else                 wr_b = wr_b & ~bus.i_weA;
    end
  end

  // First result stage: valid flag plus this port's own write lanes/data,
  // kept for the write-first merge. Everything holds until the next request
  // so the output naturally holds between results.
  logic                  valid1_a_q, valid1_b_q;
  logic [NBYTES-1:0]     we1_a_q, we1_b_q;
  logic [DATA_WIDTH-1:0] din1_a_q, din1_b_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid1_a_q <= 1'b0;
      valid1_b_q <= 1'b0;
      we1_a_q    <= '0;
      we1_b_q    <= '0;
      din1_a_q   <= '0;
      din1_b_q   <= '0;
    end else begin
      valid1_a_q <= acc_a;
      valid1_b_q <= acc_b;
      if (acc_a) begin
        we1_a_q  <= bus.i_weA;
        din1_a_q <= bus.i_dinA;
      end
      if (acc_b) begin
        we1_b_q  <= bus.i_weB;
        din1_b_q <= bus.i_dinB;
      end
    end
  end

  logic [DATA_WIDTH-1:0] word_a, word_b;

  // One RAM per byte lane; reads are registered and always see the
  // pre-write contents, so cross-port readers get old data.
  genvar gi;
  for (gi = 0; gi < NBYTES; gi++) begin : g_lane
    logic [BYTE_WIDTH-1:0] mem [MEM_DEPTH];
    logic [BYTE_WIDTH-1:0] rd_a_q, rd_b_q;

    always_ff @(posedge i_clk) begin
      if (clr_we) begin
        mem[clr_addr] <= '0;
      end else begin
        if (wr_a[gi]) mem[bus.i_addrA] <= bus.i_dinA[gi*BYTE_WIDTH +: BYTE_WIDTH];
        if (wr_b[gi]) mem[bus.i_addrB] <= bus.i_dinB[gi*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        rd_a_q <= '0;
        rd_b_q <= '0;
      end else begin
        if (acc_a) rd_a_q <= mem[bus.i_addrA];
        if (acc_b) rd_b_q <= mem[bus.i_addrB];
      end
    end

    // Write-first replaces only this port's own enabled lanes.
    assign word_a[gi*BYTE_WIDTH +: BYTE_WIDTH] =
      ((RDW_MODE != 0) && we1_a_q[gi]) ? din1_a_q[gi*BYTE_WIDTH +: BYTE_WIDTH] : rd_a_q;
    assign word_b[gi*BYTE_WIDTH +: BYTE_WIDTH] =
      ((RDW_MODE != 0) && we1_b_q[gi]) ? din1_b_q[gi*BYTE_WIDTH +: BYTE_WIDTH] : rd_b_q;
  end

  if (OUT_REG != 0) begin : g_oreg
    logic                  valid2_a_q, valid2_b_q;
    logic [DATA_WIDTH-1:0] dout2_a_q, dout2_b_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
        valid2_a_q <= 1'b0;
        valid2_b_q <= 1'b0;
        dout2_a_q  <= '0;
        dout2_b_q  <= '0;
      end else begin
        valid2_a_q <= valid1_a_q;
        valid2_b_q <= valid1_b_q;
        if (valid1_a_q) dout2_a_q <= word_a;
        if (valid1_b_q) dout2_b_q <= word_b;
      end
    end

    assign bus.o_doutA  = dout2_a_q;
    assign bus.o_doutB  = dout2_b_q;
    assign bus.o_validA = valid2_a_q;
    assign bus.o_validB = valid2_b_q;
  end else begin : g_noreg
    assign bus.o_doutA  = word_a;
    assign bus.o_doutB  = word_b;
    assign bus.o_validA = valid1_a_q;
    assign bus.o_validB = valid1_b_q;
  end

  // Collision pulse and saturating counter
  logic        coll_q;
  logic [15:0] coll_cnt_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      coll_q     <= 1'b0;
      coll_cnt_q <= '0;
    end else begin
      coll_q <= coll;
      if (coll && (coll_cnt_q != 16'hFFFF)) coll_cnt_q <= coll_cnt_q + 16'd1;
    end
  end

  assign bus.o_collision  = coll_q;
  assign bus.o_coll_count = coll_cnt_q;
endmodule

// File: tb/tb_wb_dpbram_be.sv
// Testbench for wb_dpbram_be. Two instances receive identical stimulus:
//   inst 0: RDW_MODE=0, OUT_REG=0, PRIORITY_B=0
//   inst 1: RDW_MODE=1, OUT_REG=1, PRIORITY_B=1
// A word-level reference model predicts both every cycle.
module tb_wb_dpbram_be;
  localparam int DW = 32;
  localparam int BW = 8;
  localparam int AW = 8;
  localparam int DEPTH = 2 ** AW;
`ifdef WB_DPBRAM_CLEAR_EN
  localparam int READY_LAT = DEPTH + 1;
`else
  localparam int READY_LAT = 1;
`endif
  localparam bit [1:0] CFG_RDW  = 2'b10;
  localparam bit [1:0] CFG_OREG = 2'b10;
  localparam bit [1:0] CFG_PRIB = 2'b10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        enA = 1'b0, enB = 1'b0;
  logic [3:0]  weA = '0, weB = '0;
  logic [7:0]  addrA = '0, addrB = '0;
  logic [31:0] dinA = '0, dinB = '0;

  wb_dpbram_be_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) bus0 ();
  wb_dpbram_be_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) bus1 ();

  wb_dpbram_be #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW),
                 .RDW_MODE(0), .OUT_REG(0), .PRIORITY_B(0))
    dut0 (.i_clk(clk), .i_reset(rst), .bus(bus0));
  wb_dpbram_be #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .ADDR_WIDTH(AW),
                 .RDW_MODE(1), .OUT_REG(1), .PRIORITY_B(1))
    dut1 (.i_clk(clk), .i_reset(rst), .bus(bus1));

  assign bus0.i_enA = enA;   assign bus1.i_enA = enA;
  assign bus0.i_weA = weA;   assign bus1.i_weA = weA;
  assign bus0.i_addrA = addrA; assign bus1.i_addrA = addrA;
  assign bus0.i_dinA = dinA; assign bus1.i_dinA = dinA;
  assign bus0.i_enB = enB;   assign bus1.i_enB = enB;
  assign bus0.i_weB = weB;   assign bus1.i_weB = weB;
  assign bus0.i_addrB = addrB; assign bus1.i_addrB = addrB;
  assign bus0.i_dinB = dinB; assign bus1.i_dinB = dinB;

  logic [1:0]             act_ready, act_coll;
  logic [1:0][15:0]       act_cnt;
  logic [1:0][1:0]        act_valid;
  logic [1:0][1:0][31:0]  act_dout;
  assign act_ready[0] = bus0.o_ready;      assign act_ready[1] = bus1.o_ready;
  assign act_coll[0]  = bus0.o_collision;  assign act_coll[1]  = bus1.o_collision;
  assign act_cnt[0]   = bus0.o_coll_count; assign act_cnt[1]   = bus1.o_coll_count;
  assign act_valid[0][0] = bus0.o_validA;  assign act_valid[0][1] = bus0.o_validB;
  assign act_valid[1][0] = bus1.o_validA;  assign act_valid[1][1] = bus1.o_validB;
  assign act_dout[0][0]  = bus0.o_doutA;   assign act_dout[0][1]  = bus0.o_doutB;
  assign act_dout[1][0]  = bus1.o_doutA;   assign act_dout[1][1]  = bus1.o_doutB;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  logic [31:0] mmem [2][DEPTH];
  bit          mkn  [2][DEPTH];     // word content known to the model
  bit          m_ready;
  int          rel_cnt;
  bit          m_coll [2];
  int          m_cnt  [2];
  logic [31:0] e_dout [2][2];
  bit          e_kn   [2][2];
  bit          e_valid[2][2];
  logic [31:0] p_data [2][2];
  bit          p_kn   [2][2];
  bit          p_valid[2][2];

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] we);
    logic [31:0] r = old;
    for (int k = 0; k < 4; k++) if (we[k]) r[k*8 +: 8] = nw[k*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] fillv(logic [7:0] a);
    return {8'hA5, a, ~a, 8'h3C};
  endfunction

  task automatic mwrite(int i, logic [7:0] a, logic [31:0] d, logic [3:0] we);
    mmem[i][a] = merge(mmem[i][a], d, we);
    if (we == 4'hF) mkn[i][a] = 1'b1;
  endtask

  task automatic deliver(int i, int p, bit acc, logic [31:0] res, bit kn);
    if (CFG_OREG[i]) begin
      e_valid[i][p] = p_valid[i][p];
      if (p_valid[i][p]) begin e_dout[i][p] = p_data[i][p]; e_kn[i][p] = p_kn[i][p]; end
      p_valid[i][p] = acc;
      if (acc) begin p_data[i][p] = res; p_kn[i][p] = kn; end
    end else begin
      e_valid[i][p] = acc;
      if (acc) begin e_dout[i][p] = res; e_kn[i][p] = kn; end
    end
  endtask

  task automatic model_step(int i);
    bit acc_a, acc_b, coll, kn_a, kn_b;
    logic [31:0] res_a, res_b;
    acc_a = enA && m_ready;
    acc_b = enB && m_ready;
    res_a = mmem[i][addrA]; kn_a = mkn[i][addrA];
    res_b = mmem[i][addrB]; kn_b = mkn[i][addrB];
    if (CFG_RDW[i]) begin
      res_a = merge(res_a, dinA, weA); if (weA == 4'hF) kn_a = 1'b1;
      res_b = merge(res_b, dinB, weB); if (weB == 4'hF) kn_b = 1'b1;
    end
    coll = acc_a && acc_b && (addrA == addrB) && (weA != 0) && (weB != 0);
    if (coll) begin
      // loser first, winner on top
      if (CFG_PRIB[i]) begin mwrite(i, addrA, dinA, weA); mwrite(i, addrB, dinB, weB); end
      else             begin mwrite(i, addrB, dinB, weB); mwrite(i, addrA, dinA, weA); end
      if ((weA | weB) == 4'hF) mkn[i][addrA] = 1'b1;
    end else begin
      if (acc_a) mwrite(i, addrA, dinA, weA);
      if (acc_b) mwrite(i, addrB, dinB, weB);
    end
    m_coll[i] = coll;
    if (coll && m_cnt[i] < 65535) m_cnt[i]++;
    deliver(i, 0, acc_a, res_a, kn_a);
    deliver(i, 1, acc_b, res_b, kn_b);
  endtask

  task automatic model_ready_step();
    if (!m_ready) begin
      rel_cnt++;
      if (rel_cnt >= READY_LAT) begin
        m_ready = 1'b1;
`ifdef WB_DPBRAM_CLEAR_EN
        for (int i = 0; i < 2; i++)
          for (int a = 0; a < DEPTH; a++) begin mmem[i][a] = '0; mkn[i][a] = 1'b1; end
`endif
      end
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    rel_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      m_coll[i] = 1'b0;
      m_cnt[i]  = 0;
      for (int p = 0; p < 2; p++) begin
        e_dout[i][p] = '0; e_kn[i][p] = 1'b1; e_valid[i][p] = 1'b0; p_valid[i][p] = 1'b0;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all();
    string pn;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d.ready", i), {31'b0, act_ready[i]}, {31'b0, m_ready});
      chk($sformatf("i%0d.collision", i), {31'b0, act_coll[i]}, {31'b0, m_coll[i]});
      chk($sformatf("i%0d.coll_count", i), {16'b0, act_cnt[i]}, 32'(m_cnt[i]));
      for (int p = 0; p < 2; p++) begin
        pn = (p == 0) ? "A" : "B";
        chk($sformatf("i%0d.valid%s", i, pn), {31'b0, act_valid[i][p]}, {31'b0, e_valid[i][p]});
        if (e_kn[i][p]) chk($sformatf("i%0d.dout%s", i, pn), act_dout[i][p], e_dout[i][p]);
      end
    end
  endtask

  task automatic cycle(bit ck);
    model_step(0);
    model_step(1);
    model_ready_step();
    @(posedge clk);
    #1;
    if (ck) check_all();
  endtask

  task automatic idle();
    enA = 1'b0; enB = 1'b0; weA = '0; weB = '0;
  endtask

  task automatic apply_reset(int n);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    repeat (n) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
  endtask

  // ---------------- directed vector table (expectations for inst 0) ----------------
  typedef struct packed {
    logic        enA; logic [3:0] weA; logic [7:0] addrA; logic [31:0] dinA;
    logic        enB; logic [3:0] weB; logic [7:0] addrB; logic [31:0] dinB;
    logic        vA;  logic ckA; logic [31:0] xA;
    logic        vB;  logic ckB; logic [31:0] xB;
    logic        coll; logic [15:0] cnt;
  } vec_t;
  vec_t tbl [12];

  initial begin
    logic [31:0] exp50;
    tbl[0]  = '{1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 1'b0, 4'h0, 8'h00, 32'h0,
                1'b1, 1'b1, fillv(8'h10), 1'b0, 1'b0, 32'h0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 4'hF, 8'h20, 32'h11223344, 1'b1, 4'h0, 8'h10, 32'h0,
                1'b1, 1'b1, fillv(8'h20), 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 4'b0101, 8'h20, 32'hAABBCCDD, 1'b0, 4'h0, 8'h00, 32'h0,
                1'b1, 1'b1, 32'h11223344, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 4'h0, 8'h20, 32'h0, 1'b0, 4'h0, 8'h00, 32'h0,
                1'b1, 1'b1, 32'h11BB33DD, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 16'd0};
    tbl[4]  = '{1'b1, 4'hF, 8'h30, 32'h0, 1'b0, 4'h0, 8'h00, 32'h0,
                1'b1, 1'b1, fillv(8'h30), 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 16'd0};
    tbl[5]  = '{1'b1, 4'hF, 8'h30, 32'h5A5A5A5A, 1'b1, 4'h0, 8'h30, 32'h0,
                1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 16'd0};
    tbl[6]  = '{1'b1, 4'h0, 8'h30, 32'h0, 1'b0, 4'h0, 8'h00, 32'h0,
                1'b1, 1'b1, 32'h5A5A5A5A, 1'b0, 1'b1, 32'h0, 1'b0, 16'd0};
    tbl[7]  = '{1'b1, 4'b0011, 8'h40, 32'hAAAAAAAA, 1'b1, 4'b1110, 8'h40, 32'hBBBBBBBB,
                1'b1, 1'b1, fillv(8'h40), 1'b1, 1'b1, fillv(8'h40), 1'b1, 16'd1};
    tbl[8]  = '{1'b1, 4'h0, 8'h40, 32'h0, 1'b1, 4'h0, 8'h40, 32'h0,
                1'b1, 1'b1, 32'hBBBBAAAA, 1'b1, 1'b1, 32'hBBBBAAAA, 1'b0, 16'd1};
    tbl[9]  = '{1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 4'h0, 8'h00, 32'h0,
                1'b0, 1'b1, 32'hBBBBAAAA, 1'b0, 1'b1, 32'hBBBBAAAA, 1'b0, 16'd1};
    tbl[10] = '{1'b1, 4'h0, 8'h41, 32'hFFFFFFFF, 1'b1, 4'hF, 8'h41, 32'h12345678,
                1'b1, 1'b1, fillv(8'h41), 1'b1, 1'b1, fillv(8'h41), 1'b0, 16'd1};
    tbl[11] = '{1'b1, 4'h0, 8'h41, 32'h0, 1'b0, 4'h0, 8'h00, 32'h0,
                1'b1, 1'b1, 32'h12345678, 1'b0, 1'b1, fillv(8'h41), 1'b0, 16'd1};

    for (int i = 0; i < 2; i++)
      for (int a = 0; a < DEPTH; a++) begin mmem[i][a] = '0; mkn[i][a] = 1'b0; end

    // Initial reset and wait for ready
    apply_reset(2);
    repeat (READY_LAT) cycle(1);

    // Fill every word with a known pattern (A even, B odd addresses)
    for (int k = 0; k < DEPTH / 2; k++) begin
      enA = 1'b1; weA = 4'hF; addrA = 8'(2 * k);     dinA = fillv(8'(2 * k));
      enB = 1'b1; weB = 4'hF; addrB = 8'(2 * k + 1); dinB = fillv(8'(2 * k + 1));
      cycle(1);
    end
    idle();
    cycle(1);

    // Directed table
    for (int v = 0; v < 12; v++) begin
      enA = tbl[v].enA; weA = tbl[v].weA; addrA = tbl[v].addrA; dinA = tbl[v].dinA;
      enB = tbl[v].enB; weB = tbl[v].weB; addrB = tbl[v].addrB; dinB = tbl[v].dinB;
      cycle(1);
      $display("vec %0d: A en=%0b we=%h addr=%h din=%h | B en=%0b we=%h addr=%h din=%h -> doutA=%h doutB=%h coll=%0b cnt=%0d",
               v, enA, weA, addrA, dinA, enB, weB, addrB, dinB,
               bus0.o_doutA, bus0.o_doutB, bus0.o_collision, bus0.o_coll_count);
      chk($sformatf("vec%0d.validA", v), {31'b0, bus0.o_validA}, {31'b0, tbl[v].vA});
      if (tbl[v].ckA) chk($sformatf("vec%0d.doutA", v), bus0.o_doutA, tbl[v].xA);
      chk($sformatf("vec%0d.validB", v), {31'b0, bus0.o_validB}, {31'b0, tbl[v].vB});
      if (tbl[v].ckB) chk($sformatf("vec%0d.doutB", v), bus0.o_doutB, tbl[v].xB);
      chk($sformatf("vec%0d.collision", v), {31'b0, bus0.o_collision}, {31'b0, tbl[v].coll});
      chk($sformatf("vec%0d.coll_count", v), {16'b0, bus0.o_coll_count}, {16'b0, tbl[v].cnt});
    end
    idle();
    cycle(1);

    // Output-register pipeline on inst 1: three back-to-back reads
    enA = 1'b1; weA = 4'h0; addrA = 8'h10; cycle(1);
    $display("oreg seq: read 010");
    chk("oreg.e1.validA", {31'b0, bus1.o_validA}, 32'd0);
    addrA = 8'h11; cycle(1);
    $display("oreg seq: read 011, doutA=%h", bus1.o_doutA);
    chk("oreg.e2.validA", {31'b0, bus1.o_validA}, 32'd1);
    chk("oreg.e2.doutA", bus1.o_doutA, 32'hDEADBEEF);
    addrA = 8'h12; cycle(1);
    $display("oreg seq: read 012, doutA=%h", bus1.o_doutA);
    chk("oreg.e3.validA", {31'b0, bus1.o_validA}, 32'd1);
    chk("oreg.e3.doutA", bus1.o_doutA, fillv(8'h11));
    idle(); cycle(1);
    chk("oreg.e4.validA", {31'b0, bus1.o_validA}, 32'd1);
    chk("oreg.e4.doutA", bus1.o_doutA, fillv(8'h12));
    cycle(1);
    chk("oreg.e5.validA", {31'b0, bus1.o_validA}, 32'd0);
    chk("oreg.e5.doutA", bus1.o_doutA, fillv(8'h12));

    // Reset with a result in flight: nothing valid after release
    enA = 1'b1; weA = 4'h0; addrA = 8'h10; cycle(1);
    idle();
    apply_reset(1);
    $display("mid-op reset released");
    for (int k = 0; k < 3; k++) begin
      cycle(1);
      chk("midrst.i1.validA", {31'b0, bus1.o_validA}, 32'd0);
    end
    repeat (READY_LAT) cycle(1);

    // Reset partway through the ready delay, then requests before ready
    apply_reset(2);
    repeat (READY_LAT / 2) cycle(1);
    apply_reset(1);
    enA = 1'b1; weA = 4'hF; addrA = 8'h50; dinA = 32'hBAD0BAD0;
    for (int k = 0; k < READY_LAT - 1; k++) begin
      cycle(1);
      if (k == 0 || k == READY_LAT - 2) begin
        chk("preready.ready", {31'b0, bus0.o_ready}, 32'd0);
        chk("preready.validA", {31'b0, bus0.o_validA}, 32'd0);
      end
    end
    cycle(1);
    $display("ready after %0d cycles", READY_LAT);
    chk("ready.rise", {31'b0, bus0.o_ready}, 32'd1);
    chk("ready.validA", {31'b0, bus0.o_validA}, 32'd0);
    weA = 4'h0; cycle(1);
`ifdef WB_DPBRAM_CLEAR_EN
    exp50 = 32'h0;
`else
    exp50 = fillv(8'h50);
`endif
    $display("read 050 after ignored write: %h", bus0.o_doutA);
    chk("ignored_write.doutA", bus0.o_doutA, exp50);
    idle(); cycle(1);

    // Randomized traffic on a small address window to force conflicts
    for (int k = 0; k < 3000; k++) begin
      enA = ($urandom_range(0, 3) != 0); weA = 4'($urandom_range(0, 15));
      addrA = 8'(8'h80 + $urandom_range(0, 7)); dinA = $urandom;
      enB = ($urandom_range(0, 3) != 0); weB = 4'($urandom_range(0, 15));
      addrB = 8'(8'h80 + $urandom_range(0, 7)); dinB = $urandom;
      cycle(1);
    end
    idle(); cycle(1);
    $display("random phase done, counts %0d/%0d", bus0.o_coll_count, bus1.o_coll_count);

    // Saturate the collision counter
    enA = 1'b1; weA = 4'b0001; addrA = 8'h90; dinA = 32'h11111111;
    enB = 1'b1; weB = 4'b0010; addrB = 8'h90; dinB = 32'h22222222;
    for (int k = 0; k < 70000; k++) cycle(0);
    cycle(1);
    $display("saturation: counts %h/%h", bus0.o_coll_count, bus1.o_coll_count);
    chk("sat.i0.coll_count", {16'b0, bus0.o_coll_count}, 32'h0000FFFF);
    chk("sat.i1.coll_count", {16'b0, bus1.o_coll_count}, 32'h0000FFFF);
    chk("sat.i0.collision", {31'b0, bus0.o_collision}, 32'd1);
    idle(); cycle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
